hex_entry_bank: RTL and testbench

- Button-driven hex editor for a bank of NUM_REGS registers, each DIGITS hex digits wide, for Nexys4 board front-ends. It feeds operands to datapaths under test and a cursor mask to the 7-segment blink logic.
- Next generation of the two-operand entry block. Adds a parametrised register count and width, edge-detected presses with auto-repeat, an optional carry mode, a change strobe, and asynchronous reset.

---
 rtl/hex_entry_bank_if.sv | 54 +++++
 rtl/hex_entry_bank.sv | 185 ++++++++++++++++++
 tb/tb_hex_entry_bank.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hex_entry_bank_if.sv
// hex_entry_bank_if
//   Bundles the edit controls and register/cursor outputs of hex_entry_bank.
//   The master modport drives the buttons and edit controls. The slave modport
//   is the editor itself.
//   Optional macro HEX_ENTRY_CLEAR_EN adds the btn_c clear button.
// Signals:
//   en          edit enable
//   sel         register being edited
//   carry_mode  0: digit wraps alone, 1: ripple carry/borrow across register
//   btn_l/r/u/d cursor left/right, digit increment/decrement
//   btn_c       clear selected register (HEX_ENTRY_CLEAR_EN only)
//   regs        flattened registers, reg k at [k*W +: W]
//   cursor      current digit index, 0 = LSD
//   blink       one-hot of cursor
//   changed     one-cycle pulse after a register value changes
interface hex_entry_bank_if #(
    parameter int NUM_REGS = 2,
    parameter int DIGITS   = 8
);
    localparam int W  = 4 * DIGITS;
    localparam int SW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                   en;
    logic [SW-1:0]          sel;
    logic                   carry_mode;
    logic                   btn_l;
    logic                   btn_r;
    logic                   btn_u;
    logic                   btn_d;
`ifdef HEX_ENTRY_CLEAR_EN
    logic                   btn_c;
`endif
    logic [NUM_REGS*W-1:0]  regs;
    logic [CW-1:0]          cursor;
    logic [DIGITS-1:0]      blink;
    logic                   changed;

    modport master (
`ifdef HEX_ENTRY_CLEAR_EN
        output btn_c,
`endif
        output en, sel, carry_mode, btn_l, btn_r, btn_u, btn_d,
        input  regs, cursor, blink, changed
    );

    modport slave (
`ifdef HEX_ENTRY_CLEAR_EN
        input  btn_c,
`endif
        input  en, sel, carry_mode, btn_l, btn_r, btn_u, btn_d,
        output regs, cursor, blink, changed
    );
endinterface

// File: rtl/hex_entry_bank.sv
// hex_entry_bank
//   Button-driven hex editor for NUM_REGS registers of DIGITS hex digits each.
//   Presses are edge-detected. The active button (priority L > R > U > D) can
//   auto-repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
//   Setting REPEAT_DELAY = 0 turns auto-repeat off.
//   Optional macro HEX_ENTRY_CLEAR_EN adds btn_c. Its rising edge loads the
//   selected register with RESET_VALUE and homes the cursor. It never repeats.
// Ports:
//   clk  system clock
//   rst  asynchronous active-high reset
//   bus  hex_entry_bank_if.slave. It carries en, sel, carry_mode, the buttons,
//        regs, cursor, blink and changed.
module hex_entry_bank #(
    parameter int                  NUM_REGS      = 2,
    parameter int                  DIGITS        = 8,
    parameter logic [4*DIGITS-1:0] RESET_VALUE   = '0,
    parameter int                  REPEAT_DELAY  = 0,
    parameter int                  REPEAT_PERIOD = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    hex_entry_bank_if.slave        bus
);
    localparam int W       = 4 * DIGITS;
    localparam int CW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
`ifdef HEX_ENTRY_CLEAR_EN
    localparam int NB      = 5;
`else
    localparam int NB      = 4;
`endif
    localparam logic [CNTW-1:0] DLY_LD = CNTW'(REPEAT_DELAY);
    localparam logic [CNTW-1:0] PER_LD = CNTW'(REPEAT_PERIOD);

    // Button index equals its bit position in btns.
    localparam logic [1:0] B_D = 2'd0;
    localparam logic [1:0] B_U = 2'd1;
    localparam logic [1:0] B_R = 2'd2;
    localparam logic [1:0] B_L = 2'd3;

    typedef enum logic [1:0] {IDLE, HOLD, REPT} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [1:0]      act_q, act_d, act_now;
    logic [NB-1:0]   btns, prev_q, seen_q;
    logic            rise, fire, clr_evt, sel_ok, changed_q, changed_d;
    logic [CW-1:0]   cursor_q, cursor_d;
    logic [W-1:0]    regs_q [NUM_REGS];
    logic [W-1:0]    regs_d [NUM_REGS];

    function automatic logic [W-1:0] step_nibble(input logic [W-1:0] v, input int idx,
                                                 input logic up);
        logic [W-1:0] r;
        r = v;
        r[4*idx +: 4] = up ? (v[4*idx +: 4] + 4'd1) : (v[4*idx +: 4] - 4'd1);
        return r;
    endfunction

    function automatic logic [W-1:0] step_carry(input logic [W-1:0] v, input int idx,
                                                input logic up);
        logic [W-1:0] inc;
        inc = W'(1) << (4 * idx);
        return up ? (v + inc) : (v - inc);
    endfunction

`ifdef HEX_ENTRY_CLEAR_EN
    assign btns = {bus.btn_c, bus.btn_l, bus.btn_r, bus.btn_u, bus.btn_d};
`else
    assign btns = {bus.btn_l, bus.btn_r, bus.btn_u, bus.btn_d};
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        act_d     = act_q;
        fire      = 1'b0;
        clr_evt   = 1'b0;
        regs_d    = regs_q;
        cursor_d  = cursor_q;
        changed_d = 1'b0;
        sel_ok    = int'(bus.sel) < NUM_REGS;

        if (btns[B_L])      act_now = B_L;
        else if (btns[B_R]) act_now = B_R;
        else if (btns[B_U]) act_now = B_U;
        else                act_now = B_D;

        // seen_q masks a button that has been high since reset. That button
        // has to be sampled low once before it can count as a press.
        rise = |(btns[3:0] & ~prev_q[3:0] & seen_q[3:0]);
`ifdef HEX_ENTRY_CLEAR_EN
        clr_evt = btns[4] & ~prev_q[4] & seen_q[4];
`endif

        // Repeat FSM
        case (state_q)
            IDLE: begin
                // With repeat disabled, only a press out of all-released fires.
                if (rise && (REPEAT_DELAY != 0 || prev_q[3:0] == 4'b0000)) begin
                    fire  = 1'b1;
                    act_d = act_now;
                    if (REPEAT_DELAY != 0) begin
                        cnt_d   = DLY_LD;
                        state_d = HOLD;
                    end
                end
            end
            HOLD, REPT: begin
                if (!btns[act_q]) begin
                    state_d = IDLE;
                end else if (act_now != act_q) begin
                    fire    = 1'b1;
                    act_d   = act_now;
                    cnt_d   = DLY_LD;
                    state_d = HOLD;
                end else if (cnt_q == CNTW'(1)) begin
                    fire    = 1'b1;
                    cnt_d   = PER_LD;
                    state_d = REPT;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Event effects
        if (bus.en) begin
            if (clr_evt) begin
                cursor_d = '0;
                if (sel_ok) regs_d[bus.sel] = RESET_VALUE;
            end else if (fire) begin
                case (act_now)
                    B_L: cursor_d = (cursor_q == CW'(DIGITS - 1)) ? '0 : cursor_q + CW'(1);
                    B_R: cursor_d = (cursor_q == '0) ? CW'(DIGITS - 1) : cursor_q - CW'(1);
                    default: begin
                        if (sel_ok) begin
                            if (bus.carry_mode)
                                regs_d[bus.sel] = step_carry(regs_q[bus.sel], int'(cursor_q),
                                                             act_now == B_U);
                            else
                                regs_d[bus.sel] = step_nibble(regs_q[bus.sel], int'(cursor_q),
                                                              act_now == B_U);
                        end
                    end
                endcase
            end
        end

        for (int k = 0; k < NUM_REGS; k++) begin
            if (regs_d[k] != regs_q[k]) changed_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            act_q     <= B_D;
            prev_q    <= '0;
            seen_q    <= '0;
            cursor_q  <= '0;
            changed_q <= 1'b0;
            for (int k = 0; k < NUM_REGS; k++) regs_q[k] <= RESET_VALUE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            act_q     <= act_d;
            prev_q    <= btns;
            seen_q    <= seen_q | ~btns;
            cursor_q  <= cursor_d;
            changed_q <= changed_d;
            regs_q    <= regs_d;
        end
    end

    for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
        assign bus.regs[k*W +: W] = regs_q[k];
    end
    assign bus.cursor  = cursor_q;
    assign bus.blink   = DIGITS'(1) << cursor_q;
    assign bus.changed = changed_q;
endmodule

// File: tb/tb_hex_entry_bank.sv
// tb_hex_entry_bank
//   Directed bench for hex_entry_bank. Instance u0 has auto-repeat off.
//   Instance u1 uses REPEAT_DELAY = 10 and REPEAT_PERIOD = 4.
//   Inputs change on the falling edge. Outputs are sampled there too.
module tb_hex_entry_bank;
    localparam int BL = 0;
    localparam int BR = 1;
    localparam int BU = 2;
    localparam int BD = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   pulses;

    always #5 clk = ~clk;

    hex_entry_bank_if #(.NUM_REGS(2), .DIGITS(8)) if0 ();
    hex_entry_bank_if #(.NUM_REGS(2), .DIGITS(8)) if1 ();

    hex_entry_bank #(
        .NUM_REGS(2), .DIGITS(8), .RESET_VALUE(32'h0),
        .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
    ) u0 (
        .clk(clk), .rst(rst), .bus(if0)
    );

    hex_entry_bank #(
        .NUM_REGS(2), .DIGITS(8), .RESET_VALUE(32'h0),
        .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
    ) u1 (
        .clk(clk), .rst(rst), .bus(if1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One-cycle press of a u0 button followed by one released cycle.
    task automatic press0(input int b);
        case (b)
            BL: if0.btn_l = 1'b1;
            BR: if0.btn_r = 1'b1;
            BU: if0.btn_u = 1'b1;
            default: if0.btn_d = 1'b1;
        endcase
        @(negedge clk);
        if0.btn_l = 1'b0;
        if0.btn_r = 1'b0;
        if0.btn_u = 1'b0;
        if0.btn_d = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        if0.en = 1'b1; if0.sel = '0; if0.carry_mode = 1'b0;
        if0.btn_l = 1'b0; if0.btn_r = 1'b0; if0.btn_u = 1'b0; if0.btn_d = 1'b0;
        if1.en = 1'b1; if1.sel = '0; if1.carry_mode = 1'b0;
        if1.btn_l = 1'b0; if1.btn_r = 1'b0; if1.btn_u = 1'b0; if1.btn_d = 1'b0;
`ifdef HEX_ENTRY_CLEAR_EN
        if0.btn_c = 1'b0;
        if1.btn_c = 1'b0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_reg0", if0.regs[31:0], 32'h0);
        check("rst_reg1", if0.regs[63:32], 32'h0);
        check("rst_cursor", 32'(if0.cursor), 32'd0);
        check("rst_blink", 32'(if0.blink), 32'h01);
        check("rst_changed", 32'(if0.changed), 32'd0);
        check("rst_u1_reg0", if1.regs[31:0], 32'h0);

        // Held button with repeat off: exactly one increment
        pulses = 0;
        if0.btn_u = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            pulses += int'(if0.changed);
        end
        if0.btn_u = 1'b0;
        @(negedge clk);
        check("hold_single_inc", if0.regs[31:0], 32'h00000001);
        check("hold_one_pulse", 32'(pulses), 32'd1);

        // Cursor wrap
        press0(BR);
        check("r_wrap_cursor", 32'(if0.cursor), 32'd7);
        check("r_wrap_blink", 32'(if0.blink), 32'h80);
        press0(BL);
        check("l_wrap_cursor", 32'(if0.cursor), 32'd0);
        if0.btn_l = 1'b1;
        @(negedge clk);
        check("cursor_no_changed", 32'(if0.changed), 32'd0);
        if0.btn_l = 1'b0;
        @(negedge clk);
        check("l_cursor", 32'(if0.cursor), 32'd1);
        check("l_blink", 32'(if0.blink), 32'h02);

        // Digit and carry modes on register 1
        press0(BR);
        if0.sel = 1'b1;
        if0.btn_d = 1'b1;
        @(negedge clk);
        check("dec_changed", 32'(if0.changed), 32'd1);
        if0.btn_d = 1'b0;
        @(negedge clk);
        check("dec_nibble_wrap", if0.regs[63:32], 32'h0000000F);
        press0(BU);
        check("inc_nibble_wrap", if0.regs[63:32], 32'h00000000);
        press0(BD);
        if0.carry_mode = 1'b1;
        press0(BU);
        check("inc_carry", if0.regs[63:32], 32'h00000010);
        press0(BL);
        if0.carry_mode = 1'b0;
        press0(BD);
        check("dec_nibble1", if0.regs[63:32], 32'h00000000);
        if0.carry_mode = 1'b1;
        press0(BD);
        check("dec_borrow", if0.regs[63:32], 32'hFFFFFFF0);
        if0.carry_mode = 1'b0;
        press0(BU);
        check("inc_no_carry", if0.regs[63:32], 32'hFFFFFF00);
        check("reg0_untouched", if0.regs[31:0], 32'h00000001);

        // Auto-repeat: events on edges 0, 10, 14, 18 of a 22-edge hold
        if1.btn_u = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(negedge clk);
            if (k == 1)  check("rep_e0", if1.regs[31:0], 32'd1);
            if (k == 10) check("rep_before_e10", if1.regs[31:0], 32'd1);
            if (k == 11) check("rep_e10", if1.regs[31:0], 32'd2);
            if (k == 14) check("rep_before_e14", if1.regs[31:0], 32'd2);
            if (k == 15) check("rep_e14", if1.regs[31:0], 32'd3);
            if (k == 19) check("rep_e18", if1.regs[31:0], 32'd4);
        end
        if1.btn_u = 1'b0;
        @(negedge clk);
        check("rep_total", if1.regs[31:0], 32'h00000004);

        // en low during repeat freezes the value; re-enable waits for a tick
        if1.btn_u = 1'b1;
        repeat (11) @(negedge clk);
        check("en_pre", if1.regs[31:0], 32'd6);
        if1.en = 1'b0;
        repeat (8) @(negedge clk);
        check("en_frozen", if1.regs[31:0], 32'd6);
        if1.en = 1'b1;
        repeat (3) @(negedge clk);
        check("en_no_fire", if1.regs[31:0], 32'd6);
        @(negedge clk);
        check("en_next_tick", if1.regs[31:0], 32'd7);
        if1.btn_u = 1'b0;
        @(negedge clk);

        // Reset while held in REPT
        if1.btn_u = 1'b1;
        repeat (12) @(negedge clk);
        check("rst_pre", if1.regs[31:0], 32'd9);
        rst = 1'b1;
        #1;
        check("rst_async_u1", if1.regs[31:0], 32'h0);
        check("rst_async_u0", if0.regs[63:32], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("held_after_rst", if1.regs[31:0], 32'h0);
        check("held_after_rst_chg", 32'(if1.changed), 32'd0);
        if1.btn_u = 1'b0;
        @(negedge clk);
        if1.btn_u = 1'b1;
        @(negedge clk);
        check("repress_after_rst", if1.regs[31:0], 32'd1);
        if1.btn_u = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
